load_data_cache: RTL and testbench
==================================

// Module: load_data_cache
// PURPOSE
//  Direct-mapped, one-word-per-line read cache serving the load reservation
//  stations' cache port (c_ptr/c_read_enable -> c_out/c_hit), downstream of the loaders.
//  Misses are refilled from data memory over a req/ack handshake.
//  A write-through port from the store path keeps resident lines coherent.
// PARAMETERS
//  WORD_SIZE   32  data/address word width (matches parameters.v)
//  ADDR_WIDTH  16  significant address bits taken from c_ptr[ADDR_WIDTH-1:0]
//  IDX_BITS    4   index bits; LINES = 2**IDX_BITS = 16
// PORTS
//  clk            in   1           single clock, all state on posedge
//  reset_n        in   1           asynchronous, active-low reset
//  c_read_enable  in   1           load request strobe, sampled only in IDLE
//  c_ptr          in   WORD_SIZE   load word address
//  c_out          out  WORD_SIZE   load data, valid while c_ready=1
//  c_hit          out  1           1 = request hit, 0 = served by refill; valid with c_ready
//  c_ready        out  1           one-cycle response pulse
//  c_busy         out  1           1 whenever state != IDLE
//  wr_en          in   1           store write-through strobe
//  wr_addr        in   WORD_SIZE   store address
//  wr_data        in   WORD_SIZE   store data
//  mem_req        out  1           refill request, held until mem_ack
//  mem_addr       out  ADDR_WIDTH  refill address, stable while mem_req=1
//  mem_ack        in   1           memory returns mem_rdata this cycle
//  mem_rdata      in   WORD_SIZE   refill data
// BEHAVIOUR
//  - Address split: idx = a[IDX_BITS-1:0], tag = a[ADDR_WIDTH-1:IDX_BITS].
//    Upper c_ptr bits are ignored. Arrays: valid[LINES], tag[LINES], data[LINES].
//  - Reset (reset_n=0, async): all valid bits 0, state IDLE.
//    c_out=0, c_hit=0, c_ready=0, c_busy=0, mem_req=0, mem_addr=0.
//    Reset mid-refill drops mem_req immediately; a late mem_ack is ignored.
//  - FSM:
//    IDLE:   c_read_enable=1 -> latch addr, go to LOOKUP. Otherwise stay.
//    LOOKUP: tag compare.
//            Hit  -> c_out=data[idx], c_hit=1, c_ready=1 for this cycle, go to IDLE.
//                    Hit latency: strobe at cycle N, c_ready at N+1.
//            Miss -> go to MREQ.
//    MREQ:   mem_req=1, mem_addr=latched addr, held until mem_ack=1.
//            On ack: write line (valid=1, tag, data=mem_rdata), go to RESP.
//    RESP:   c_out=filled data, c_hit=0, c_ready=1 for one cycle, go to IDLE.
//            The same-cycle mem_ack path goes through RESP; there is no bypass.
//  - c_ready is exactly one cycle per accepted request. c_out and c_hit hold their
//    last values afterwards; the consumer samples them only on c_ready.
//  - A new request issued in the same cycle as c_ready (state=IDLE next) is
//    accepted in the following cycle; c_read_enable while c_busy=1 is ignored.
//    An accepted request always completes, even if c_read_enable drops.
//  - Write-through (any state): if valid[wi] and tag match -> data[wi]=wr_data.
//    A write never allocates or invalidates a line.
//  - Write vs. in-flight read to the same address (full ADDR_WIDTH match):
//    LOOKUP hit -> c_out returns wr_data (forward).
//    MREQ ack cycle -> fill stores and returns wr_data, not mem_rdata.
//    MREQ before ack -> address is recorded; the fill uses the recorded wr_data.
//  - Conflicting fills evict the old line silently; there is no dirty state.
// TESTING
//  1 Reset then read 0x0013: miss, mem_req with mem_addr=0x0013.
//    Ack on the 3rd cycle with 0xDEADBEEF -> c_ready, c_hit=0, c_out=0xDEADBEEF.
//  2 Re-read 0x0013 -> c_ready exactly 1 cycle after the strobe, c_hit=1,
//    c_out=0xDEADBEEF, mem_req stays 0.
//  3 Read 0x0023 (same idx 3, tag 2): miss evicts the line. Then read 0x0013:
//    miss again -> refill.
//  4 wr_en to 0x0023 with 0x12345678 while the line is resident, then read 0x0023
//    -> hit, c_out=0x12345678. wr_en to 0x0044 (absent), then read 0x0044 -> miss.
//  5 Read 0x0050 (miss), wr_en 0x0050=0xAAAA0001 during MREQ, ack with 0x0 ->
//    c_out=0xAAAA0001; the next read is a hit returning 0xAAAA0001.
//  6 Pull reset_n low during MREQ -> mem_req=0 and c_busy=0 at once. Ack after
//    release is ignored; reading 0x0013 misses because valid bits were cleared.

Source files
------------

// File: rtl/load_data_cache.sv
// Direct-mapped one-word-per-line load data cache.
// Misses refill over req/ack; stores write through to resident lines.
module load_data_cache #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int IDX_BITS   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  c_read_enable,
  input  logic [WORD_SIZE-1:0]  c_ptr,
  output logic [WORD_SIZE-1:0]  c_out,
  output logic                  c_hit,
  output logic                  c_ready,
  output logic                  c_busy,
  input  logic                  wr_en,
  input  logic [WORD_SIZE-1:0]  wr_addr,
  input  logic [WORD_SIZE-1:0]  wr_data,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [WORD_SIZE-1:0]  mem_rdata
);

  localparam int LINES    = 2 ** IDX_BITS;
  localparam int TAG_BITS = ADDR_WIDTH - IDX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MREQ,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q [LINES];
  logic [WORD_SIZE-1:0]  data_q [LINES];
  logic [WORD_SIZE-1:0]  fill_q;
  logic [WORD_SIZE-1:0]  out_q;
  logic                  hit_q;
  logic                  fwd_q;
  logic [WORD_SIZE-1:0]  fwd_data_q;

  logic [IDX_BITS-1:0]   idx;
  logic [TAG_BITS-1:0]   tag;
  logic [ADDR_WIDTH-1:0] wa;
  logic [IDX_BITS-1:0]   wi;
  logic [TAG_BITS-1:0]   wt;
  logic                  lookup_hit;
  logic                  wr_same;
  logic                  wr_hit;
  logic                  fill_now;
  logic                  rec_now;
  logic [WORD_SIZE-1:0]  fill_data;
  logic                  unused_bits;

  assign idx = addr_q[IDX_BITS-1:0];
  assign tag = addr_q[ADDR_WIDTH-1:IDX_BITS];
  assign wa  = wr_addr[ADDR_WIDTH-1:0];
  assign wi  = wa[IDX_BITS-1:0];
  assign wt  = wa[ADDR_WIDTH-1:IDX_BITS];

  assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag);
  assign wr_same    = wr_en && (wa == addr_q);
  assign wr_hit     = wr_en && valid_q[wi] && (tag_q[wi] == wt);
  assign fill_now   = (state_q == MREQ) && mem_ack;

  // Store to the in-flight address must win over stale memory data.
  assign rec_now = wr_same &&
    ((state_q == MREQ) ||
     ((state_q == LOOKUP) && !lookup_hit));

  assign fill_data = wr_same ? wr_data :
                     fwd_q   ? fwd_data_q :
                               mem_rdata;

  assign c_busy   = (state_q != IDLE);
  assign mem_addr = addr_q;

  assign unused_bits = ^{c_ptr[WORD_SIZE-1:ADDR_WIDTH],
                         wr_addr[WORD_SIZE-1:ADDR_WIDTH]};

  always_comb begin
    state_d = state_q;
    c_ready = 1'b0;
    c_hit   = hit_q;
    c_out   = out_q;
    mem_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (c_read_enable) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (lookup_hit) begin
          c_ready = 1'b1;
          c_hit   = 1'b1;
          c_out   = wr_same ? wr_data : data_q[idx];
          state_d = IDLE;
        end else begin
          state_d = MREQ;
        end
      end
      MREQ: begin
        mem_req = 1'b1;
        if (mem_ack) state_d = RESP;
      end
      RESP: begin
        c_ready = 1'b1;
        c_hit   = 1'b0;
        c_out   = fill_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      valid_q    <= '0;
      fill_q     <= '0;
      out_q      <= '0;
      hit_q      <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && c_read_enable) begin
        addr_q <= c_ptr[ADDR_WIDTH-1:0];
        fwd_q  <= 1'b0;
      end
      if (rec_now) begin
        fwd_q      <= 1'b1;
        fwd_data_q <= wr_data;
      end
      if (fill_now) begin
        valid_q[idx] <= 1'b1;
        fill_q       <= fill_data;
      end
      if (c_ready) begin
        out_q <= c_out;
        hit_q <= c_hit;
      end
    end
  end

  // Fill is ordered last so it wins over a same-index write-through.
  always_ff @(posedge clk) begin
    if (wr_hit) data_q[wi] <= wr_data;
    if (fill_now) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= fill_data;
    end
  end

endmodule

// File: tb/tb_load_data_cache.sv
// Randomized bench for load_data_cache.
// Reference model: per-line resident address/data plus store-forward rules.
module tb_load_data_cache;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        c_read_enable;
  logic [31:0] c_ptr;
  logic [31:0] c_out;
  logic        c_hit;
  logic        c_ready;
  logic        c_busy;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_data_cache dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .c_read_enable(c_read_enable),
    .c_ptr        (c_ptr),
    .c_out        (c_out),
    .c_hit        (c_hit),
    .c_ready      (c_ready),
    .c_busy       (c_busy),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  int n_chk  = 0;
  int n_pass = 0;

  bit          mv [16];
  logic [15:0] ma [16];
  logic [31:0] mdat [16];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic void m_clear();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
  endfunction

  function automatic void m_write(input logic [15:0] a,
                                  input logic [31:0] d);
    if (mv[a[3:0]] && ma[a[3:0]] == a) mdat[a[3:0]] = d;
  endfunction

  function automatic void m_fill(input logic [15:0] a,
                                 input logic [31:0] d);
    mv[a[3:0]]   = 1'b1;
    ma[a[3:0]]   = a;
    mdat[a[3:0]] = d;
  endfunction

  task automatic drive_wr(input logic [15:0] a,
                          input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = {16'($urandom), a};
    wr_data = d;
  endtask

  task automatic write_only(input logic [15:0] a,
                            input logic [31:0] d);
    @(negedge clk);
    drive_wr(a, d);
    m_write(a, d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // wcyc: -1 none, 0 lookup cycle, k = k-th refill cycle (dly+1 = ack)
  task automatic read_txn(input logic [15:0] a,
                          input logic [31:0] md,
                          input int dly,
                          input int wcyc,
                          input logic [15:0] wa,
                          input logic [31:0] wd);
    bit          hit;
    bit          fwd;
    logic [31:0] fwdd;
    logic [31:0] exp;
    fwd  = 1'b0;
    fwdd = '0;
    @(negedge clk);
    wr_en         = 1'b0;
    mem_ack       = 1'b0;
    c_read_enable = 1'b1;
    c_ptr         = {16'($urandom), a};
    #1 chk("idle_busy", c_busy, 0);
    @(negedge clk);
    c_read_enable = 1'($urandom);
    hit = mv[a[3:0]] && ma[a[3:0]] == a;
    if (wcyc == 0) drive_wr(wa, wd);
    #1;
    chk("lk_ready", c_ready, hit);
    chk("lk_busy", c_busy, 1);
    chk("lk_req", mem_req, 0);
    if (hit) begin
      exp = (wcyc == 0 && wa == a) ? wd : mdat[a[3:0]];
      chk("hit_out", c_out, exp);
      chk("hit_flag", c_hit, 1);
      if (wcyc == 0) m_write(wa, wd);
      @(negedge clk);
      wr_en = 1'b0;
      c_read_enable = 1'b0;
      #1 chk("hit_after", c_ready, 0);
      chk("hit_idle", c_busy, 0);
      return;
    end
    if (wcyc == 0) begin
      if (wa == a) begin
        fwd  = 1'b1;
        fwdd = wd;
      end
      m_write(wa, wd);
    end
    for (int k = 1; k <= dly + 1; k++) begin
      @(negedge clk);
      c_read_enable = 1'b0;
      wr_en     = 1'b0;
      mem_ack   = (k == dly + 1);
      mem_rdata = (k == dly + 1) ? md : $urandom;
      if (wcyc == k) drive_wr(wa, wd);
      #1;
      chk("mreq", mem_req, 1);
      chk("maddr", mem_addr, a);
      chk("mreq_rdy", c_ready, 0);
      if (wcyc == k) begin
        if (wa == a) begin
          fwd  = 1'b1;
          fwdd = wd;
        end
        m_write(wa, wd);
      end
    end
    exp = fwd ? fwdd : md;
    m_fill(a, exp);
    @(negedge clk);
    mem_ack = 1'b0;
    wr_en   = 1'b0;
    #1;
    chk("resp_ready", c_ready, 1);
    chk("resp_hit", c_hit, 0);
    chk("resp_out", c_out, exp);
    chk("resp_req", mem_req, 0);
    @(negedge clk);
    #1;
    chk("resp_after", c_ready, 0);
    chk("resp_idle", c_busy, 0);
    chk("hold_out", c_out, exp);
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] wa;
    int dly;
    int wcyc;
    reset_n       = 1'b0;
    c_read_enable = 1'b0;
    c_ptr         = '0;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    mem_ack       = 1'b0;
    mem_rdata     = '0;
    m_clear();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out", c_out, 0);
    chk("rst_hit", c_hit, 0);
    chk("rst_ready", c_ready, 0);
    chk("rst_busy", c_busy, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    reset_n = 1'b1;

    read_txn(16'h0013, 32'hDEADBEEF, 2, -1, 0, 0);
    read_txn(16'h0013, 32'h0, 0, -1, 0, 0);
    read_txn(16'h0023, 32'h00230023, 1, -1, 0, 0);
    read_txn(16'h0013, 32'h00130013, 0, -1, 0, 0);
    read_txn(16'h0023, 32'h02302300, 0, -1, 0, 0);
    write_only(16'h0023, 32'h12345678);
    read_txn(16'h0023, 32'h0, 0, -1, 0, 0);
    chk("t4_data", c_out, 32'h12345678);
    write_only(16'h0044, 32'h44444444);
    read_txn(16'h0044, 32'h04400440, 1, -1, 0, 0);
    read_txn(16'h0050, 32'h0, 2, 1, 16'h0050, 32'hAAAA0001);
    read_txn(16'h0050, 32'h0, 0, -1, 0, 0);
    chk("t5_hit", c_out, 32'hAAAA0001);

    @(negedge clk);
    c_read_enable = 1'b1;
    c_ptr         = 32'h0000_0060;
    @(negedge clk);
    c_read_enable = 1'b0;
    @(negedge clk);
    #1 chk("t6_req", mem_req, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_req0", mem_req, 0);
    chk("t6_busy0", c_busy, 0);
    chk("t6_out0", c_out, 0);
    @(negedge clk);
    reset_n   = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    #1;
    chk("t6_ack_busy", c_busy, 0);
    chk("t6_ack_rdy", c_ready, 0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1 chk("t6_late", c_busy, 0);
    m_clear();
    read_txn(16'h0013, 32'h13131313, 1, -1, 0, 0);

    for (int n = 0; n < 300; n++) begin
      a  = 16'(($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
      wa = ($urandom_range(0, 1) == 1) ? a :
           16'(($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        write_only(wa, $urandom);
      end else begin
        dly  = $urandom_range(0, 3);
        wcyc = $urandom_range(0, dly + 2) - 1;
        read_txn(a, $urandom, dly, wcyc, wa, $urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
